// File: rtl/gm_scoreboard.sv
// Golden-model scoreboard: shadows the APB register file, queues expected results, compares on DUT done.
// Compare pulses/counters update one clk after the done edge; pushes while full are dropped (overflow).
module gm_scoreboard #(
   parameter int DATA_WIDTH      = 32,
   parameter int AMBA_ADDR_WIDTH = 20,
   parameter int AMBA_WORD       = 32,
   parameter int DEPTH           = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   input  logic                       exp_valid,
   input  logic [DATA_WIDTH-1:0]      exp_data,
   input  logic                       operation_done,
   input  logic [DATA_WIDTH-1:0]      dut_data_out,
   input  logic [1:0]                 dut_num_of_errors,
   output logic [AMBA_WORD-1:0]       gm_PRDATA,
   output logic [AMBA_WORD-1:0]       CTRL_REG,
   output logic                       match,
   output logic                       mismatch,
   output logic                       skip,
   output logic                       overflow,
   output logic                       underflow,
   output logic [15:0]                pass_cnt,
   output logic [15:0]                fail_cnt,
   output logic [$clog2(DEPTH):0]     q_count
);

   localparam int AW  = $clog2(DEPTH);
   localparam int NW  = (AMBA_WORD < DATA_WIDTH) ? AMBA_WORD : DATA_WIDTH;
   localparam int PCW = $clog2(DATA_WIDTH + 1);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            nof;
      logic                  unsup;
      logic [1:0]            mode;
   } entry_t;

   logic [AMBA_WORD-1:0]  ctrl_q, data_in_q, cw_q, noise_q, prdata_q, prdata_d;
   entry_t                mem_q [DEPTH];
   entry_t                push_ent, head;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q, count_d;
   logic                  done_q;
   logic                  match_q, mismatch_q, skip_q, overflow_q, underflow_q;
   logic [15:0]           pass_q, fail_q, pass_d, fail_d;
   logic [DATA_WIDTH-1:0] mask, noise_ext;
   logic [PCW-1:0]        pc;
   logic [1:0]            exp_nof;
   logic                  exp_unsup;
   logic                  done_edge, q_empty, q_full, pop, push, cmp, entry_pass, data_ok;
   logic                  apb_wr, apb_rd;

   // Active codeword width as a bit mask; width code 11 means the full data path.
   always_comb begin
      mask = '0;
      case (cw_q[1:0])
         2'b00:   mask[7:0]  = '1;
         2'b01:   mask[15:0] = '1;
         2'b10:   mask[31:0] = '1;
         default: mask       = '1;
      endcase
   end

   always_comb begin
      noise_ext = '0;
      noise_ext[NW-1:0] = noise_q[NW-1:0];
      pc = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         pc = pc + PCW'(noise_ext[i] & mask[i]);
      end
   end

   always_comb begin
      exp_nof   = 2'b00;
      exp_unsup = 1'b0;
      if (ctrl_q[1:0] != 2'b00) begin
         case (pc)
            PCW'(0): exp_nof = 2'b00;
            PCW'(1): exp_nof = 2'b01;
            PCW'(2): exp_nof = 2'b10;
            default: begin
               exp_nof   = 2'b11;
               exp_unsup = 1'b1;
            end
         endcase
      end
   end

   assign push_ent   = '{data: exp_data, nof: exp_nof, unsup: exp_unsup, mode: ctrl_q[1:0]};
   assign head       = mem_q[rd_ptr_q];
   assign done_edge  = operation_done & ~done_q;
   assign q_empty    = (count_q == '0);
   assign q_full     = (count_q == (AW+1)'(DEPTH));
   assign pop        = done_edge & ~q_empty;
   assign push       = exp_valid & (~q_full | pop);
   assign cmp        = pop & ~head.unsup;
   assign data_ok    = ((dut_data_out ^ head.data) & mask) == '0;
   // An expected NOF of 10 means the data word is uncorrectable, so only the count is judged.
   assign entry_pass = (head.nof == dut_num_of_errors) && ((head.nof == 2'b10) || data_ok);
   assign apb_wr     = PSEL & PENABLE & PWRITE;
   assign apb_rd     = PSEL & PENABLE & ~PWRITE;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
      pass_d = pass_q;
      fail_d = fail_q;
      if (cmp && entry_pass && pass_q != 16'hFFFF)  pass_d = pass_q + 16'd1;
      if (cmp && !entry_pass && fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
      prdata_d = prdata_q;
      if (apb_rd) begin
         case (PADDR[3:2])
            2'b00:   prdata_d = ctrl_q;
            2'b01:   prdata_d = data_in_q;
            2'b10:   prdata_d = cw_q;
            default: prdata_d = noise_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ctrl_q      <= '0;
         data_in_q   <= '0;
         cw_q        <= '0;
         noise_q     <= '0;
         prdata_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         match_q     <= 1'b0;
         mismatch_q  <= 1'b0;
         skip_q      <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         pass_q      <= '0;
         fail_q      <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (apb_wr) begin
            case (PADDR[3:2])
               2'b00:   ctrl_q    <= PWDATA;
               2'b01:   data_in_q <= PWDATA;
               2'b10:   cw_q      <= PWDATA;
               default: noise_q   <= PWDATA;
            endcase
         end
         if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
         prdata_q    <= prdata_d;
         count_q     <= count_d;
         done_q      <= operation_done;
         match_q     <= cmp & entry_pass;
         mismatch_q  <= cmp & ~entry_pass;
         skip_q      <= pop & head.unsup;
         overflow_q  <= exp_valid & q_full & ~pop;
         underflow_q <= done_edge & q_empty;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{PADDR, head.mode};

   assign gm_PRDATA = prdata_q;
   assign CTRL_REG  = ctrl_q;
   assign match     = match_q;
   assign mismatch  = mismatch_q;
   assign skip      = skip_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign pass_cnt  = pass_q;
   assign fail_cnt  = fail_q;
   assign q_count   = count_q;

endmodule
